// File: rtl/demux_1x4_reg.sv
// Registered 1-to-NUM_OUT demultiplexer with a one-entry valid/ready holding register per lane.
// Optional round-robin lane selection (in_sel ignored, sel_ptr exposed) when DEMUX_AUTO_SEL_EN is defined.
module demux_1x4_reg #(
    parameter int DATA_WIDTH = 4,
    parameter int SEL_WIDTH  = 2,
    localparam int NUM_OUT   = 2 ** SEL_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [SEL_WIDTH-1:0]          in_sel,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]            out_valid,
    input  logic [NUM_OUT-1:0]            out_ready,
`ifdef DEMUX_AUTO_SEL_EN
    output logic [SEL_WIDTH-1:0]          sel_ptr,
`endif
    output logic                          busy
);

    logic [DATA_WIDTH-1:0] data_p1 [NUM_OUT];
    logic [NUM_OUT-1:0]    vld_p1;
    logic [SEL_WIDTH-1:0]  lane_sel;
    logic                  accept;

`ifdef DEMUX_AUTO_SEL_EN
    logic [SEL_WIDTH-1:0]  ptr;
    logic                  in_sel_unused;

    // Lane choice comes from the round-robin pointer; in_sel is intentionally dropped.
    assign in_sel_unused = ^in_sel;
    assign lane_sel      = ptr;
    assign sel_ptr       = ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr + SEL_WIDTH'(1);
        end
    end
`else
    assign lane_sel = in_sel;
`endif

    // A full lane can still accept when its consumer drains it in the same cycle.
    assign in_ready = rst_n & (~vld_p1[lane_sel] | out_ready[lane_sel]);
    assign accept   = in_valid & in_ready;

    // Stage p0 -> p1: per-lane holding registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                data_p1[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (accept && (lane_sel == SEL_WIDTH'(k))) begin
                    data_p1[k] <= in_data;
                    vld_p1[k]  <= 1'b1;
                end else if (out_ready[k]) begin
                    vld_p1[k]  <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_lane
        assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = data_p1[g];
    end

    assign out_valid = vld_p1;
    assign busy      = |vld_p1;

endmodule

// File: tb/tb_demux_1x4_reg.sv
// Self-checking bench for demux_1x4_reg: lane scoreboard plus directed checks.
// Covers the round-robin build as well when DEMUX_AUTO_SEL_EN is defined.
module tb_demux_1x4_reg;

    localparam int DW = 4;
    localparam int SW = 2;
    localparam int NO = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [DW-1:0]  in_data;
    logic [SW-1:0]  in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [NO*DW-1:0] out_data;
    logic [NO-1:0]  out_valid;
    logic [NO-1:0]  out_ready;
    logic           busy;
`ifdef DEMUX_AUTO_SEL_EN
    logic [SW-1:0]  sel_ptr;
`endif

    demux_1x4_reg #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef DEMUX_AUTO_SEL_EN
        .sel_ptr  (sel_ptr),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            lane;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sbq[$];
    logic [NO-1:0] m_vld = '0;
    logic [SW-1:0] m_ptr = '0;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_data(input int k);
        return out_data[k*DW +: DW];
    endfunction

    // One clock: check the handshake against the model, update the scoreboard, then check registered outputs.
    task automatic tick();
        int   s;
        logic exp_rdy;
        int   idx;
        #1;
`ifdef DEMUX_AUTO_SEL_EN
        s = int'(m_ptr);
        chk("sel_ptr", 32'(sel_ptr), 32'(m_ptr));
`else
        s = int'(in_sel);
`endif
        exp_rdy = rst_n & (~m_vld[s] | out_ready[s]);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (!rst_n) begin
            sbq.delete();
            m_vld = '0;
            m_ptr = '0;
        end else begin
            for (int k = 0; k < NO; k++) begin
                if (m_vld[k] && out_ready[k]) begin
                    idx = -1;
                    for (int i = 0; i < sbq.size(); i++)
                        if (idx < 0 && sbq[i].lane == k) idx = i;
                    if (idx < 0) begin
                        chk($sformatf("sb_lane%0d_missing", k), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("lane%0d_data", k), 32'(lane_data(k)), 32'(sbq[idx].data));
                        sbq.delete(idx);
                    end
                    m_vld[k] = 1'b0;
                end
            end
            if (in_valid && exp_rdy) begin
                sbq.push_back('{lane: s, data: in_data});
                m_vld[s] = 1'b1;
                m_ptr    = m_ptr + SW'(1);
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        chk("busy", 32'(busy), 32'(|m_vld));
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] s);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
    endtask

    initial begin
        logic [DW-1:0] vals [4];
        vals[0] = 4'hA; vals[1] = 4'h5; vals[2] = 4'h3; vals[3] = 4'hC;
        rst_n     = 1'b0;
        out_ready = 4'b0000;
        drive(1'b1, 4'h5, 2'd0);

        // Reset held for 3 cycles with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_out_data", 32'(out_data), 32'd0);
        end
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 2'd0);
        tick();

`ifndef DEMUX_AUTO_SEL_EN
        // Basic routing, one word per lane on consecutive cycles
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i], SW'(i));
            tick();
            chk($sformatf("route_vld%0d", i), 32'(out_valid), 32'(4'b0001 << i));
            chk($sformatf("route_data%0d", i), 32'(lane_data(i)), 32'(vals[i]));
        end
        drive(1'b0, 4'h0, 2'd2);
        tick();

        // Back-pressure isolation on lane 1
        out_ready = 4'b1101;
        drive(1'b1, 4'h1, 2'd1);
        tick();
        drive(1'b1, 4'h2, 2'd1);
        #1 chk("bp_stall_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        chk("bp_hold_data", 32'(lane_data(1)), 32'h1);
        out_ready = 4'b1111;
        #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_refill_data", 32'(lane_data(1)), 32'h2);
        drive(1'b1, 4'h7, 2'd3);
        tick();
        chk("bp_lane3_vld", 32'(out_valid), 32'(4'b1000));
        chk("bp_lane3_data", 32'(lane_data(3)), 32'h7);
        drive(1'b0, 4'h0, 2'd0);
        tick();

        // Same-cycle drain and refill of lane 0
        out_ready = 4'b0000;
        drive(1'b1, 4'hF, 2'd0);
        tick();
        out_ready = 4'b0001;
        drive(1'b1, 4'h9, 2'd0);
        #1 chk("refill_ready", 32'(in_ready), 32'd1);
        tick();
        chk("refill_data", 32'(lane_data(0)), 32'h9);
        chk("refill_vld", 32'(out_valid[0]), 32'd1);

        // Idle input with garbage select must not disturb any lane
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'(i + 4), SW'($urandom_range(0, 3)));
            tick();
        end
        chk("idle_data0", 32'(lane_data(0)), 32'h9);

        // Reset mid-operation with lanes 0 and 2 full
        drive(1'b1, 4'h6, 2'd2);
        tick();
        drive(1'b0, 4'h0, 2'd0);
        rst_n = 1'b0;
        tick();
        chk("midrst_vld", 32'(out_valid), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        rst_n     = 1'b1;
        out_ready = 4'b1111;
        tick();
        tick();
        chk("midrst_no_stale", 32'(out_valid), 32'd0);
`else
        // Round-robin stream, in_sel randomised and ignored
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i), SW'($urandom_range(0, 3)));
            tick();
            chk($sformatf("rr_vld%0d", i), 32'(out_valid), 32'(4'b0001 << (i % 4)));
            chk($sformatf("rr_data%0d", i), 32'(lane_data(i % 4)), 32'(i));
        end
        chk("rr_wrap_ptr", 32'(sel_ptr), 32'd0);
        drive(1'b0, 4'h0, 2'd0);
        tick();

        // Stall lane 1 and confirm the pointer freezes on it
        out_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(8 + i), SW'($urandom_range(0, 3)));
            tick();
        end
        drive(1'b1, 4'hD, SW'($urandom_range(0, 3)));
        tick();
        tick();
        chk("rr_freeze_ptr", 32'(sel_ptr), 32'd1);
        chk("rr_freeze_data", 32'(lane_data(1)), 32'h9);
        out_ready = 4'b1111;
        tick();
        chk("rr_release_data", 32'(lane_data(1)), 32'hD);
        chk("rr_release_ptr", 32'(sel_ptr), 32'd2);
        drive(1'b0, 4'h0, 2'd0);
`endif

        out_ready = 4'b1111;
        drive(1'b0, 4'h0, 2'd0);
        tick();
        tick();
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1x4_reg.md
Name: demux_1x4_reg

Overview:
- Registered 1-to-4 demultiplexer. It is the distribution-side counterpart of the 4-to-1 select tree.
- Steers each accepted input word to the output lane chosen by a select field.
- Each lane has a one-entry holding register with a valid/ready handshake, so a stalled lane back-pressures only the words addressed to it.
- Sits between a single producer and four independent consumers in the datapath.

Parameters:
- DATA_WIDTH, 4, width of each data word.
- SEL_WIDTH, 2, select width; NUM_OUT = 2**SEL_WIDTH lanes (4 at default).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_data  input  DATA_WIDTH  input word.
- in_sel  input  SEL_WIDTH  destination lane for in_data.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block accepts the word this cycle.
- out_data  output  NUM_OUT*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  NUM_OUT  lane k holding register full.
- out_ready  input  NUM_OUT  consumer k takes the word this cycle.
- busy  output  1  OR of out_valid.

Behaviour:
- Reset: all state is sampled on a clk edge with rst_n=0.
  - out_valid = 0, out_data = 0, busy = 0.
  - in_ready is forced to 0 in any cycle where rst_n=0.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Lane-k output transfer occurs when out_valid[k] & out_ready[k].
- Ready rule: in_ready = rst_n & (~out_valid[s] | out_ready[s]), where s = in_sel (or the internal pointer, see Optional Feature).
  - in_ready is combinational from in_sel and out_ready. This is the only combinational path.
- Latency: a word accepted at edge N appears on out_data/out_valid of lane s after edge N (1 cycle).
- Lane k next state:
  - Accept into k (with or without a simultaneous drain): out_data[k] <= in_data, out_valid[k] <= 1. Same-cycle drain+refill gives back-to-back throughput of 1 word/cycle per lane.
  - Drain only: out_valid[k] <= 0. out_data[k] holds its stale value.
  - Otherwise: hold.
- At most one lane is written per cycle. Drains on any subset of lanes may occur in the same cycle as that write.
- Full lane s with out_ready[s]=0:
  - in_ready=0 and the input word is not consumed.
  - The producer must hold in_data/in_sel stable until accepted.
  - Other lanes continue draining.
- in_valid=0: no lane is written, regardless of in_sel.
- X/garbage on in_sel while in_valid=0 must not affect any state.
- Reset mid-operation (rst_n=0 while lanes are full): all pending words are discarded next edge. No output transfer is counted in the reset cycle.
- out_data of a lane with out_valid=0 is don't-care for consumers. The RTL keeps it stable (no toggling when not written).

Optional Feature:
- Macro: DEMUX_AUTO_SEL_EN.
- Defined:
  - in_sel is ignored.
  - An internal SEL_WIDTH-bit pointer ptr selects the lane. ptr resets to 0 and increments modulo NUM_OUT on every input transfer, so the block acts as a 1:NUM_OUT round-robin deserializer.
  - ptr does not advance while in_ready=0.
  - Output port sel_ptr (SEL_WIDTH, output) exposes ptr.
- Not defined:
  - The lane is in_sel.
  - No pointer logic and no sel_ptr port exist.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=4'b0000, out_data=0, busy=0 throughout.
- Basic routing: out_ready=4'b1111; send data 4'hA,4'h5,4'h3,4'hC with sel 0,1,2,3 on consecutive cycles -> each lane k shows its word with out_valid[k]=1 exactly 1 cycle after acceptance; lane 2 shows 4'h3 with out_valid=4'b0100 in its cycle.
- Back-pressure isolation: out_ready=4'b1101 (lane 1 stalled), send 4'h1 sel=1, then 4'h2 sel=1, then 4'h7 sel=3 ->
  - 4'h1 is accepted.
  - 4'h2 sees in_ready=0 and is held while the producer keeps it asserted.
  - Raising out_ready[1] drains 4'h1 and accepts 4'h2 in the same cycle.
  - 4'h7 is then accepted on the following cycle and routed to lane 3.
- Same-cycle drain+refill: lane 0 full with 4'hF, out_ready[0]=1, in 4'h9 sel=0 -> in_ready=1; next cycle out_data lane0=4'h9, out_valid[0]=1.
- Reset mid-operation: lanes 0 and 2 full, out_ready=0; pulse rst_n=0 for 1 cycle -> out_valid=4'b0000 next cycle; no stale word reappears afterwards.
- DEMUX_AUTO_SEL_EN defined: stream 8 words 4'h0..4'h7 with out_ready=1111 and random in_sel ->
  - Lanes receive 0,1,2,3,0,1,2,3 (lane0: 4'h0 then 4'h4).
  - sel_ptr wraps 3->0.
  - Stalling lane 1 freezes sel_ptr at 1 until drained.
